// File: rtl/multi_button_led_toggle_pkg.sv
// rtl/multi_button_led_toggle_pkg.sv - edge-mode constants and counter sizing helper
package multi_button_led_toggle_pkg;

    localparam int EDGE_FALL = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_BOTH = 2;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/multi_button_led_toggle_if.sv
// rtl/multi_button_led_toggle_if.sv - button/LED bundle; MULTI_BUTTON_LONG_PRESS_EN adds o_Long_Press
interface multi_button_led_toggle_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] i_Button;
    logic              i_Clear;
    logic [NUM_CH-1:0] o_LED;
    logic [NUM_CH-1:0] o_Btn_State;
    logic [NUM_CH-1:0] o_Toggle;
`ifdef MULTI_BUTTON_LONG_PRESS_EN
    logic [NUM_CH-1:0] o_Long_Press;

    modport master (
        output i_Button, i_Clear,
        input  o_LED, o_Btn_State, o_Toggle, o_Long_Press
    );
    modport slave (
        input  i_Button, i_Clear,
        output o_LED, o_Btn_State, o_Toggle, o_Long_Press
    );
`else
    modport master (
        output i_Button, i_Clear,
        input  o_LED, o_Btn_State, o_Toggle
    );
    modport slave (
        input  i_Button, i_Clear,
        output o_LED, o_Btn_State, o_Toggle
    );
`endif
endinterface

// File: rtl/multi_button_led_toggle_debounce_ch.sv
// rtl/multi_button_led_toggle_debounce_ch.sv - one channel: sync, debounce, edges; hold counter under MULTI_BUTTON_LONG_PRESS_EN
module button_debounce_ch
    import multi_button_led_toggle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
`ifdef MULTI_BUTTON_LONG_PRESS_EN
    ,
    parameter int LONG_CYCLES = 1000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic rise,
    output logic fall
`ifdef MULTI_BUTTON_LONG_PRESS_EN
    ,
    output logic long_press,
    output logic long_held
`endif
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] count;

    // Any sample matching the accepted level restarts the stability count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            count    <= '0;
        end else begin
            sync1    <= button;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign level = stable;
    assign rise  = stable & ~stable_d;
    assign fall  = ~stable & stable_d;

`ifdef MULTI_BUTTON_LONG_PRESS_EN
    localparam int HW = cnt_width(LONG_CYCLES);

    logic [HW-1:0] hold;

    // Saturating at LONG_CYCLES (one past the pulse point) makes the pulse single-shot.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold       <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= stable && (hold == HW'(LONG_CYCLES - 1));
            if (!stable) begin
                hold <= '0;
            end else if (hold != HW'(LONG_CYCLES)) begin
                hold <= hold + 1'b1;
            end
        end
    end

    assign long_held = (hold == HW'(LONG_CYCLES));
`endif

endmodule

// File: rtl/multi_button_led_toggle.sv
// rtl/multi_button_led_toggle.sv - N-channel debounced button LED toggle; MULTI_BUTTON_LONG_PRESS_EN enables long-press
module multi_button_led_toggle
    import multi_button_led_toggle_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int EDGE_MODE       = EDGE_FALL,
    parameter bit INIT_LED        = 1'b0
`ifdef MULTI_BUTTON_LONG_PRESS_EN
    ,
    parameter int LONG_CYCLES     = 1000000
`endif
) (
    input logic                      i_Clk,
    input logic                      i_Rst,
    multi_button_led_toggle_if.slave bus
);
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] held_long;
    logic [NUM_CH-1:0] qual;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] toggle;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
`ifdef MULTI_BUTTON_LONG_PRESS_EN
        button_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_ch (
            .clk       (i_Clk),
            .rst       (i_Rst),
            .button    (bus.i_Button[c]),
            .level     (level[c]),
            .rise      (rise[c]),
            .fall      (fall[c]),
            .long_press(bus.o_Long_Press[c]),
            .long_held (held_long[c])
        );
`else
        button_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (i_Clk),
            .rst   (i_Rst),
            .button(bus.i_Button[c]),
            .level (level[c]),
            .rise  (rise[c]),
            .fall  (fall[c])
        );
        assign held_long[c] = 1'b0;
`endif
    end

    // A release that ends a long press is swallowed; presses are never suppressed.
    always_comb begin
        qual = '0;
        case (EDGE_MODE)
            EDGE_RISE: qual = rise;
            EDGE_BOTH: qual = rise | (fall & ~held_long);
            default:   qual = fall & ~held_long;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            led    <= {NUM_CH{INIT_LED}};
            toggle <= '0;
        end else begin
            toggle <= qual;
            if (bus.i_Clear) begin
                led <= '0;
            end else begin
                led <= led ^ qual;
            end
        end
    end

    assign bus.o_LED       = led;
    assign bus.o_Btn_State = level;
    assign bus.o_Toggle    = toggle;

endmodule

// File: doc/multi_button_led_toggle.md
Name: multi_button_led_toggle

Overview:
- N-channel successor to the single-button falling-edge LED toggle.
- Each channel synchronises a raw push-button input, debounces it with a parametrised stability counter, and detects a selectable edge (falling, rising or both).
- Each detected edge toggles that channel's LED.
- Sits between board button pins and LED pins; also exports the debounced levels and edge pulses to other logic.

Parameters:
- NUM_CH, 4, number of independent button/LED channels (>=1).
- DEBOUNCE_CYCLES, 250000, consecutive clocks a synchronised input must differ from the stable level before it is accepted (>=1).
- EDGE_MODE, 0, edge that toggles the LED: 0 = falling (release), 1 = rising (press), 2 = both.
- INIT_LED, 0, reset value of every o_LED bit.
- LONG_CYCLES, 1000000, hold time for long-press detection; used only with the optional feature (> DEBOUNCE_CYCLES).

Ports:
- i_Clk  in  1  single system clock; all logic on rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_Button  in  NUM_CH  raw asynchronous buttons, 1 = pressed.
- i_Clear  in  1  synchronous clear of all LEDs to 0.
- o_LED  out  NUM_CH  toggled LED state per channel.
- o_Btn_State  out  NUM_CH  debounced button level.
- o_Toggle  out  NUM_CH  one-cycle pulse on the clock where that channel's LED toggles.

Behaviour:
- Reset, with i_Rst high at a rising edge:
  - sync flops, stable level, and debounce counter all clear to 0;
  - o_LED = {NUM_CH{INIT_LED}};
  - o_Btn_State = 0;
  - o_Toggle = 0.
- Reset mid-debounce discards the partial count. Reset dominates i_Clear and every edge event.
- Synchroniser: two flops per channel (sync1, sync2). No combinational path from i_Button to any output.
- Debounce counter:
  - width $clog2(DEBOUNCE_CYCLES+1); unsigned; never wraps.
  - If sync2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync2 and counter <= 0.
  - Else: counter <= counter+1.
- Glitch rejection: any return of sync2 to the stable level before acceptance restarts the count from 0.
- o_Btn_State is the stable register.
- Edge detect, registered: rise = stable 0->1, fall = stable 1->0, qualified by EDGE_MODE.
- On the edge after a qualified stable change: o_LED[c] <= ~o_LED[c] and o_Toggle[c] <= 1. Otherwise o_Toggle[c] <= 0.
- Latency: a clean input change held steady, first sampled at edge k:
  - stable changes at edge k+1+DEBOUNCE_CYCLES;
  - o_LED toggles and o_Toggle pulses at edge k+2+DEBOUNCE_CYCLES.
- DEBOUNCE_CYCLES = 1: acceptance on the first differing cycle.
- i_Clear high at an edge: o_LED <= 0 on all channels.
  - Clear beats a simultaneous toggle: LED goes to 0.
  - o_Toggle still pulses for that event.
- Channels are fully independent. Simultaneous edges on several channels toggle all of them in the same cycle.
- EDGE_MODE = 2: press and release each toggle, so one full press/release cycle returns the LED to its prior state.

Optional Feature:
- Macro: MULTI_BUTTON_LONG_PRESS_EN.
- When defined:
  - Adds output port o_Long_Press [NUM_CH].
  - A per-channel hold counter, width $clog2(LONG_CYCLES+1), counts while stable = 1 and saturates.
  - When it reaches LONG_CYCLES-1, o_Long_Press[c] pulses for one cycle.
  - After a long press, the following release edge does not toggle the LED and does not pulse o_Toggle, in EDGE_MODE 0 and 2.
  - The hold counter clears on stable = 0 and on reset.
- When undefined: no port, no hold counter, and behaviour is exactly as above.

Decomposition:
- Shared package / header holds:
  - edge-mode constants EDGE_FALL = 0, EDGE_RISE = 1, EDGE_BOTH = 2;
  - a clog2-width helper used for counter sizing.
- Natural sub-module: button_debounce_ch, one channel covering synchroniser, debounce counter, stable register and rise/fall outputs (plus the hold counter under the macro).
- Top instantiates NUM_CH of these in a generate loop and owns the edge qualification, LED toggle flops and clear logic.

Test Plan (NUM_CH=2, DEBOUNCE_CYCLES=4, EDGE_MODE=0, INIT_LED=0, LONG_CYCLES=10):
- Reset with i_Button=2'b11 held -> o_LED=00, o_Btn_State=00, o_Toggle=00 on every cycle while i_Rst=1.
- Ch0 pressed clean, held 20 cycles, then released -> o_Btn_State[0] rises 5 edges after the press is first sampled. o_LED[0] stays 0 at press and goes 1 six edges after the release is first sampled, with a one-cycle o_Toggle[0].
- Ch1 3-cycle glitch high, then low -> o_Btn_State[1] stays 0, no toggle. A 4-cycle high pulse is accepted.
- Both channels released on the same cycle, with i_Clear asserted on the toggle edge -> o_Toggle=11 pulse, o_LED=00.
- EDGE_MODE=2, one press/release on ch0 -> two o_Toggle[0] pulses; o_LED[0] goes 0->1->0.
- MULTI_BUTTON_LONG_PRESS_EN, ch0 held 15 cycles after debounce, then released -> one o_Long_Press[0] pulse 10 edges after stable rises; the release gives no toggle and o_LED[0] stays 0.
